alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
Registered ALU operand-select stage for the DWIDTH-bit core. It sits between register-file read and the ALU.
- Builds operand A from rd and operand B from rs or one of three immediate forms.
- Resolves RAW hazards by forwarding from the EX and WB stages.
- Uses a valid/ready handshake with a one-entry skid buffer, so the ALU can stall without dropping an accepted operation.

Parameters:
DWIDTH, 16, datapath width in bits.
IMM_WIDTH, 8, immediate field width; must be less than DWIDTH.
AWIDTH, 3, register address width used for forwarding compare.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  upstream operation valid.
in_ready  out  1  stage can accept; equals NOT skid_valid.
b_sel  in  2  operand-B source: 0 SEXT imm, 1 rs, 2 ZEXT imm, 3 UPPER imm.
imm  in  IMM_WIDTH  immediate field.
rd_addr, rs_addr  in  AWIDTH each  source register addresses.
rd_q, rs_q  in  DWIDTH each  register-file read data.
fwd_ex_valid  in  1  EX result valid for forwarding.
fwd_ex_addr  in  AWIDTH  EX result destination address.
fwd_ex_data  in  DWIDTH  EX result data.
fwd_wb_valid  in  1  WB result valid for forwarding.
fwd_wb_addr  in  AWIDTH  WB result destination address.
fwd_wb_data  in  DWIDTH  WB result data.
out_valid  out  1  operands valid to ALU.
out_ready  in  1  ALU accepts operands.
alu_a, alu_b  out  DWIDTH each  registered operands.

Behaviour:
- Reset (async assert, sync release): out_valid=0, alu_a=0, alu_b=0, skid_valid=0, skid data=0. in_ready=1 from the first clock after release.
- Accept: a transfer occurs when in_valid && in_ready. Operands are resolved combinationally in the accept cycle.
- Latency: out_valid rises on the clock edge ending the accept cycle (1 cycle).
- Operand A: if fwd_ex_valid && fwd_ex_addr==rd_addr, take fwd_ex_data; else if fwd_wb_valid && fwd_wb_addr==rd_addr, take fwd_wb_data; else take rd_q. EX has priority over WB.
- Operand B, b_sel=1: rs_q with the same forwarding and priority, compared against rs_addr.
- Operand B immediates:
  - b_sel=0: sign-extended imm.
  - b_sel=2: zero-extended imm.
  - b_sel=3: imm in the upper IMM_WIDTH bits, zero below (16/8 gives {imm,8'h00}).
  - Immediates ignore forwarding.
- Register 0 is an ordinary register; there is no hardwired zero.
- Output register update:
  - Empty output (out_valid=0) or out_ready=1: load from skid if skid_valid, else from the new accept.
  - If neither source is available, out_valid becomes 0 when out_ready=1.
- Skid capture: when out_valid && !out_ready and an accept occurs, store the resolved operands in skid and set skid_valid.
- Skid drain: skid_valid clears when skid moves to the output. Ordering is strictly FIFO.
- Simultaneous drain and accept: if skid drains into the output and a new accept occurs in the same cycle, the new operation goes to skid. This cannot happen while in_ready=0, so skid never overflows.
- Stall stability: while out_valid && !out_ready, alu_a and alu_b hold stable.
- No forwarding re-evaluation: operands are resolved once at accept. Data parked in skid is not re-forwarded; upstream hazard logic guarantees correctness.
- Reset mid-operation: the output and skid contents are discarded immediately; no partial transfer occurs.

Optional Feature:
Macro ALU_STAGE_STALL_CNT_EN.
- Defined: adds output port stall_cnt (16 bits). It counts cycles with out_valid && !out_ready, saturates at 16'hFFFF, and is cleared by reset.
- Undefined: no port, no counter logic; behaviour is otherwise identical.

Decomposition:
- Package alu_stage_pkg holds:
  - B_SEL_SEXT=2'd0, B_SEL_RS=2'd1, B_SEL_ZEXT=2'd2, B_SEL_UPPER=2'd3.
  - The b_sel_t typedef.
- Sub-module operand_fwd_mux: combinational EX/WB priority forward select, parametrised by DWIDTH/AWIDTH. It is instantiated twice (A, B-rs).

Test Plan:
- Reset release → out_valid=0, alu_a=alu_b=0, in_ready=1. Accept rd_q=16'h1234, b_sel=0, imm=8'hF0 → next cycle alu_a=16'h1234, alu_b=16'hFFF0.
- Immediate forms: b_sel=2, imm=8'hF0 → alu_b=16'h00F0; b_sel=3 → alu_b=16'hF000.
- Forwarding: rd_addr=3, fwd_ex(valid, addr 3, 16'hAAAA) and fwd_wb(valid, addr 3, 16'hBBBB) → alu_a=16'hAAAA. With EX invalid → 16'hBBBB. With b_sel=1, rs_addr=5, WB addr 5 → alu_b=WB data.
- Backpressure: out_ready=0, accept op1 then op2 → op1 held on output, op2 in skid, in_ready=0. Raise out_ready → op1 then op2 delivered in order, in_ready returns to 1.
- Drain + accept in the same cycle: with skid full, set out_ready=1 and in_valid=1 → no accept that cycle (in_ready=0). Next cycle accept completes; no loss or duplication across 50 random valid/ready cycles checked against a scoreboard.
- Mid-stall reset: assert rst_n=0 with skid full → out_valid=0 immediately. After release the first accepted op appears with no stale data. With ALU_STAGE_STALL_CNT_EN defined, 5 stall cycles → stall_cnt=5.

Source files
------------

// File: rtl/alu_stage_pkg.sv
// alu_stage_pkg
// Shared definitions for the ALU operand-select stage.
//   b_sel_t     : operand-B source select encoding
//   B_SEL_*     : named values of b_sel_t
package alu_stage_pkg;

    typedef logic [1:0] b_sel_t;

    localparam b_sel_t B_SEL_SEXT  = 2'd0;  // sign-extended immediate
    localparam b_sel_t B_SEL_RS    = 2'd1;  // forwarded rs register value
    localparam b_sel_t B_SEL_ZEXT  = 2'd2;  // zero-extended immediate
    localparam b_sel_t B_SEL_UPPER = 2'd3;  // immediate in the upper bits

endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux
// Combinational bypass select for one register operand. The EX result is the
// youngest producer, so it wins over WB; the register file is the fallback.
// Ports:
//   src_addr / src_data : register address and register-file read data
//   ex_valid/addr/data  : EX-stage result bypass
//   wb_valid/addr/data  : WB-stage result bypass
//   result              : resolved operand value
module operand_fwd_mux #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 3
) (
    input  logic [AWIDTH-1:0] src_addr,
    input  logic [DWIDTH-1:0] src_data,
    input  logic              ex_valid,
    input  logic [AWIDTH-1:0] ex_addr,
    input  logic [DWIDTH-1:0] ex_data,
    input  logic              wb_valid,
    input  logic [AWIDTH-1:0] wb_addr,
    input  logic [DWIDTH-1:0] wb_data,
    output logic [DWIDTH-1:0] result
);

    logic ex_hit_s;
    logic wb_hit_s;

    // Address match per bypass source; register 0 is an ordinary register.
    always_comb begin
        ex_hit_s = ex_valid && (ex_addr == src_addr);
        wb_hit_s = wb_valid && (wb_addr == src_addr);
    end

    // Priority select: EX, then WB, then register file.
    always_comb begin
        result = src_data;
        if (ex_hit_s) begin
            result = ex_data;
        end else if (wb_hit_s) begin
            result = wb_data;
        end else begin
            result = src_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// Registered operand-select stage between register-file read and the ALU.
// Operand A comes from rd, operand B from rs or an immediate form; register
// operands are bypassed from EX/WB once, at accept time. A one-entry skid
// buffer lets the ALU stall without losing an accepted operation.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_valid / in_ready       : upstream handshake (in_ready = skid empty)
//   b_sel, imm                : operand-B source select and immediate field
//   rd_addr/rd_q, rs_addr/rs_q: register addresses and read data
//   fwd_ex_*, fwd_wb_*        : bypass sources
//   out_valid / out_ready     : downstream handshake
//   alu_a, alu_b              : registered operands
//   stall_cnt                 : saturating count of stalled output cycles,
//                               present only when ALU_STAGE_STALL_CNT_EN is defined
module alu_operand_stage
    import alu_stage_pkg::*;
#(
    parameter int DWIDTH    = 16,
    parameter int IMM_WIDTH = 8,
    parameter int AWIDTH    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           b_sel,
    input  logic [IMM_WIDTH-1:0] imm,
    input  logic [AWIDTH-1:0]    rd_addr,
    input  logic [AWIDTH-1:0]    rs_addr,
    input  logic [DWIDTH-1:0]    rd_q,
    input  logic [DWIDTH-1:0]    rs_q,
    input  logic                 fwd_ex_valid,
    input  logic [AWIDTH-1:0]    fwd_ex_addr,
    input  logic [DWIDTH-1:0]    fwd_ex_data,
    input  logic                 fwd_wb_valid,
    input  logic [AWIDTH-1:0]    fwd_wb_addr,
    input  logic [DWIDTH-1:0]    fwd_wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef ALU_STAGE_STALL_CNT_EN
    output logic [15:0]          stall_cnt,
`endif
    output logic [DWIDTH-1:0]    alu_a,
    output logic [DWIDTH-1:0]    alu_b
);

    localparam int EXT_W = DWIDTH - IMM_WIDTH;

    // Immediate forms for operand B.
    function automatic logic [DWIDTH-1:0] imm_sext(input logic [IMM_WIDTH-1:0] v);
        return {{EXT_W{v[IMM_WIDTH-1]}}, v};
    endfunction

    function automatic logic [DWIDTH-1:0] imm_zext(input logic [IMM_WIDTH-1:0] v);
        return {{EXT_W{1'b0}}, v};
    endfunction

    function automatic logic [DWIDTH-1:0] imm_upper(input logic [IMM_WIDTH-1:0] v);
        return {v, {EXT_W{1'b0}}};
    endfunction

    b_sel_t              b_sel_s;
    logic [DWIDTH-1:0]   fwd_a_s;
    logic [DWIDTH-1:0]   fwd_rs_s;
    logic [DWIDTH-1:0]   op_b_s;

    logic                accept_s;
    logic                load_en_s;
    logic                drain_s;
    logic                capture_s;

    logic                out_valid_r;
    logic [DWIDTH-1:0]   out_a_r;
    logic [DWIDTH-1:0]   out_b_r;
    logic                skid_valid_r;
    logic [DWIDTH-1:0]   skid_a_r;
    logic [DWIDTH-1:0]   skid_b_r;

    assign b_sel_s = b_sel_t'(b_sel);

    operand_fwd_mux #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) fwd_a_u (
        .src_addr (rd_addr),
        .src_data (rd_q),
        .ex_valid (fwd_ex_valid),
        .ex_addr  (fwd_ex_addr),
        .ex_data  (fwd_ex_data),
        .wb_valid (fwd_wb_valid),
        .wb_addr  (fwd_wb_addr),
        .wb_data  (fwd_wb_data),
        .result   (fwd_a_s)
    );

    operand_fwd_mux #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) fwd_rs_u (
        .src_addr (rs_addr),
        .src_data (rs_q),
        .ex_valid (fwd_ex_valid),
        .ex_addr  (fwd_ex_addr),
        .ex_data  (fwd_ex_data),
        .wb_valid (fwd_wb_valid),
        .wb_addr  (fwd_wb_addr),
        .wb_data  (fwd_wb_data),
        .result   (fwd_rs_s)
    );

    // Operand-B source select; immediates bypass forwarding entirely.
    always_comb begin
        op_b_s = {DWIDTH{1'b0}};
        case (b_sel_s)
            B_SEL_SEXT:  op_b_s = imm_sext(imm);
            B_SEL_RS:    op_b_s = fwd_rs_s;
            B_SEL_ZEXT:  op_b_s = imm_zext(imm);
            B_SEL_UPPER: op_b_s = imm_upper(imm);
            default:     op_b_s = {DWIDTH{1'b0}};
        endcase
    end

    // Handshake decode. The output register may load when it is empty or
    // being consumed. The skid only fills when an accept cannot reach the
    // output; since in_ready is low while the skid is full, a drain and an
    // accept never coincide, but capture_s still covers that case.
    always_comb begin
        accept_s  = in_valid && !skid_valid_r;
        load_en_s = !out_valid_r || out_ready;
        drain_s   = load_en_s && skid_valid_r;
        capture_s = accept_s && (!load_en_s || drain_s);
    end

    // Output register: skid contents take precedence to keep FIFO order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_a_r     <= {DWIDTH{1'b0}};
            out_b_r     <= {DWIDTH{1'b0}};
        end else if (load_en_s) begin
            if (skid_valid_r) begin
                out_valid_r <= 1'b1;
                out_a_r     <= skid_a_r;
                out_b_r     <= skid_b_r;
            end else if (accept_s) begin
                out_valid_r <= 1'b1;
                out_a_r     <= fwd_a_s;
                out_b_r     <= op_b_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Skid buffer: parks an operation accepted while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_r <= 1'b0;
            skid_a_r     <= {DWIDTH{1'b0}};
            skid_b_r     <= {DWIDTH{1'b0}};
        end else if (capture_s) begin
            skid_valid_r <= 1'b1;
            skid_a_r     <= fwd_a_s;
            skid_b_r     <= op_b_s;
        end else if (drain_s) begin
            skid_valid_r <= 1'b0;
        end else begin
            skid_valid_r <= skid_valid_r;
        end
    end

`ifdef ALU_STAGE_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles where the ALU holds off a valid operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'h0000;
        end else if (out_valid_r && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

    assign in_ready  = !skid_valid_r;
    assign out_valid = out_valid_r;
    assign alu_a     = out_a_r;
    assign alu_b     = out_b_r;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: directed vectors with hand-computed
// operands pushed into a scoreboard queue at accept time; an independent
// monitor pops and compares on every output transfer and checks that
// stalled outputs hold stable. Ends with a short random handshake phase.
module tb_alu_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  b_sel;
    logic [7:0]  imm;
    logic [2:0]  rd_addr;
    logic [2:0]  rs_addr;
    logic [15:0] rd_q;
    logic [15:0] rs_q;
    logic        fwd_ex_valid;
    logic [2:0]  fwd_ex_addr;
    logic [15:0] fwd_ex_data;
    logic        fwd_wb_valid;
    logic [2:0]  fwd_wb_addr;
    logic [15:0] fwd_wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
`ifdef ALU_STAGE_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] sb_q[$];

    alu_operand_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .b_sel        (b_sel),
        .imm          (imm),
        .rd_addr      (rd_addr),
        .rs_addr      (rs_addr),
        .rd_q         (rd_q),
        .rs_q         (rs_q),
        .fwd_ex_valid (fwd_ex_valid),
        .fwd_ex_addr  (fwd_ex_addr),
        .fwd_ex_data  (fwd_ex_data),
        .fwd_wb_valid (fwd_wb_valid),
        .fwd_wb_addr  (fwd_wb_addr),
        .fwd_wb_data  (fwd_wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
`ifdef ALU_STAGE_STALL_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .alu_a        (alu_a),
        .alu_b        (alu_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model for the random phase: later assignments override
    // earlier ones, so EX (assigned last) wins over WB.
    function automatic logic [31:0] model();
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        a = rd_q;
        if (fwd_wb_valid && fwd_wb_addr == rd_addr) a = fwd_wb_data;
        if (fwd_ex_valid && fwd_ex_addr == rd_addr) a = fwd_ex_data;
        r = rs_q;
        if (fwd_wb_valid && fwd_wb_addr == rs_addr) r = fwd_wb_data;
        if (fwd_ex_valid && fwd_ex_addr == rs_addr) r = fwd_ex_data;
        case (b_sel)
            2'd0:    b = {{8{imm[7]}}, imm};
            2'd1:    b = r;
            2'd2:    b = {8'h00, imm};
            default: b = {imm, 8'h00};
        endcase
        return {a, b};
    endfunction

    task automatic set_op(input logic [1:0] bs, input logic [7:0] im,
                          input logic [2:0] ra, input logic [15:0] rq,
                          input logic [2:0] sa, input logic [15:0] sq);
        b_sel = bs; imm = im; rd_addr = ra; rd_q = rq; rs_addr = sa; rs_q = sq;
    endtask

    task automatic set_fwd(input logic ev, input logic [2:0] ea, input logic [15:0] ed,
                           input logic wv, input logic [2:0] wa, input logic [15:0] wd);
        fwd_ex_valid = ev; fwd_ex_addr = ea; fwd_ex_data = ed;
        fwd_wb_valid = wv; fwd_wb_addr = wa; fwd_wb_data = wd;
    endtask

    // Present the prepared operation until accepted; push its expected operands.
    task automatic drive_op(input logic [15:0] ea, input logic [15:0] eb, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back({ea, eb});
                done = 1'b1;
            end else begin
                waits++;
            end
        end
        if (!done) begin
            bad++;
            total++;
            $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare each transfer with the scoreboard; check stall hold.
    bit          stall_prev = 1'b0;
    logic [31:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else if (out_valid) begin
            if (stall_prev) check("stall_hold", {alu_a, alu_b}, held);
            if (out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", {alu_a, alu_b}, 32'h0);
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    check("sb_data", {alu_a, alu_b}, sb_q.pop_front());
                end
            end
            stall_prev = !out_ready;
            held       = {alu_a, alu_b};
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        int w;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_op(2'd0, 8'h00, 3'd0, 16'h0000, 3'd0, 16'h0000);
        set_fwd(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
        #22;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu_ab", {alu_a, alu_b}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic accept, sign-extended immediate, 1-cycle latency.
        set_op(2'd0, 8'hF0, 3'd1, 16'h1234, 3'd2, 16'h0000);
        drive_op(16'h1234, 16'hFFF0, w);
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        set_op(2'd2, 8'hF0, 3'd1, 16'h0001, 3'd2, 16'h0000);
        drive_op(16'h0001, 16'h00F0, w);
        set_op(2'd3, 8'hF0, 3'd1, 16'h0002, 3'd2, 16'h0000);
        drive_op(16'h0002, 16'hF000, w);

        // Forwarding priority and rs forwarding.
        set_op(2'd0, 8'h05, 3'd3, 16'h1111, 3'd2, 16'h0000);
        set_fwd(1'b1, 3'd3, 16'hAAAA, 1'b1, 3'd3, 16'hBBBB);
        drive_op(16'hAAAA, 16'h0005, w);
        set_fwd(1'b0, 3'd3, 16'hAAAA, 1'b1, 3'd3, 16'hBBBB);
        drive_op(16'hBBBB, 16'h0005, w);
        set_op(2'd1, 8'h05, 3'd3, 16'h1111, 3'd5, 16'h2222);
        set_fwd(1'b1, 3'd3, 16'hAAAA, 1'b1, 3'd5, 16'hCCCC);
        drive_op(16'hAAAA, 16'hCCCC, w);
        // Register 0 forwards like any other; immediate ignores a matching bypass.
        set_op(2'd1, 8'h00, 3'd0, 16'h0F0F, 3'd0, 16'h0F0F);
        set_fwd(1'b1, 3'd0, 16'h1357, 1'b0, 3'd0, 16'h0000);
        drive_op(16'h1357, 16'h1357, w);
        set_op(2'd0, 8'h80, 3'd4, 16'h4444, 3'd0, 16'h0F0F);
        drive_op(16'h4444, 16'hFF80, w);
        set_fwd(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
        repeat (3) @(posedge clk); #1;

        // Backpressure: op1 on output, op2 in skid, then ordered drain.
        out_ready = 1'b0;
        set_op(2'd2, 8'h11, 3'd1, 16'h0101, 3'd2, 16'h0000);
        drive_op(16'h0101, 16'h0011, w);
        set_op(2'd2, 8'h22, 3'd1, 16'h0202, 3'd2, 16'h0000);
        drive_op(16'h0202, 16'h0022, w);
        check("skid_full_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_out_a", {16'h0, alu_a}, 32'h0101);
        out_ready = 1'b1;
        set_op(2'd2, 8'h33, 3'd1, 16'h0303, 3'd2, 16'h0000);
        drive_op(16'h0303, 16'h0033, w);
        check("drain_accept_waits", w, 32'd1);
        repeat (4) @(posedge clk); #1;
        check("in_ready_back", {31'd0, in_ready}, 32'd1);

        // Reset while the skid is full.
        out_ready = 1'b0;
        set_op(2'd2, 8'h44, 3'd1, 16'h0404, 3'd2, 16'h0000);
        drive_op(16'h0404, 16'h0044, w);
        set_op(2'd2, 8'h55, 3'd1, 16'h0505, 3'd2, 16'h0000);
        drive_op(16'h0505, 16'h0055, w);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_alu_ab", {alu_a, alu_b}, 32'h0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        set_op(2'd0, 8'h7F, 3'd6, 16'h0606, 3'd2, 16'h0000);
`ifdef ALU_STAGE_STALL_CNT_EN
        drive_op(16'h0606, 16'h007F, w);
        repeat (5) @(posedge clk); #1;
        check("stall_cnt", {16'h0, stall_cnt}, 32'd5);
        out_ready = 1'b1;
`else
        out_ready = 1'b1;
        drive_op(16'h0606, 16'h007F, w);
`endif
        repeat (2) @(posedge clk); #1;

        // Random valid/ready phase checked against the model.
        for (int i = 0; i < 50; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            set_op(2'($urandom_range(0, 3)), 8'($urandom), 3'($urandom_range(0, 7)),
                   16'($urandom), 3'($urandom_range(0, 7)), 16'($urandom));
            set_fwd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                    1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
            @(negedge clk);
            if (in_valid && in_ready) sb_q.push_back(model());
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check("final_sb_empty", sb_q.size(), 32'd0);
        check("final_out_idle", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
